// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on input and output.
// Stage 1 holds the accepted operation; stage 2 holds the computed result and flags.
// Flags are packed as {err, ovf, carry, neg, zero}.
// Optional macro ALU_PIPE_SHIFT_EN adds SLL/SRL/SRA (opcodes 0100/0101/0110);
// without it those opcodes are illegal and no shifter is built.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [4:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;
`ifdef ALU_PIPE_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam int         SHW     = $clog2(WIDTH);
`endif

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_load;
    logic             s1_advance;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;
    logic             res_err;
    logic             res_zero;

    // Stage 2 can take a new result when it is empty or its current result leaves this cycle;
    // stage 1 moves forward under exactly that condition, so in_ready sees a full-rate path.
    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;

    // Extra top bit captures carry-out for ADD and borrow for SUB.
    assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff = {1'b0, s1_a} - {1'b0, s1_b};

`ifdef ALU_PIPE_SHIFT_EN
    // Shifts run on a one-bit-extended operand so the last bit shifted out lands in the extra bit.
    logic [SHW-1:0] sh_amt;
    logic [WIDTH:0] sll_ext;
    logic [WIDTH:0] srl_ext;
    logic [WIDTH:0] sra_ext;

    assign sh_amt  = s1_b[SHW-1:0];
    assign sll_ext = {1'b0, s1_a} << sh_amt;
    assign srl_ext = {s1_a, 1'b0} >> sh_amt;
    assign sra_ext = $signed({s1_a, 1'b0}) >>> sh_amt;
`endif

    // Compute the result and raw flags for whatever operation sits in stage 1.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_err   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = !diff[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_XNOR: res = ~(s1_a ^ s1_b);
`ifdef ALU_PIPE_SHIFT_EN
            OP_SLL: begin
                res       = sll_ext[WIDTH-1:0];
                res_carry = sll_ext[WIDTH];
            end
            OP_SRL: begin
                res       = srl_ext[WIDTH:1];
                res_carry = srl_ext[0];
            end
            OP_SRA: begin
                res       = sra_ext[WIDTH:1];
                res_carry = sra_ext[0];
            end
`endif
            default: res_err = 1'b1;
        endcase
    end

    // An illegal op returns c = 0 but must not report zero.
    assign res_zero = (res == '0) && !res_err;

    // Stage 1: capture the operation on accept; empties when its op moves on and nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    // Stage 2: register result and flags when stage 1 advances; hold them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            flags     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                c     <= res;
                flags <= {res_err, res_ovf, res_carry, res[WIDTH-1], res_zero};
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, legal range 8..64.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: upstream has an operation presented.
REQ-005 SHALL have port in_ready, output, 1: block accepts the operation this cycle.
REQ-006 SHALL have port op, input, 4: opcode {s3,s2,s1,s0}.
REQ-007 SHALL have ports a and b, input, WIDTH: operands.
REQ-008 SHALL have port out_valid, output, 1: result presented.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-010 SHALL have port c, output, WIDTH: result.
REQ-011 SHALL have port flags, output, 5: {err, ovf, carry, neg, zero}.

Function
REQ-012 Transfer SHALL occur on in_valid&&in_ready (accept) and on out_valid&&out_ready (retire); no other condition moves data.
REQ-013 Opcodes SHALL be 0000 ADD, 0001 SUB (a-b), 1000 AND, 1001 OR, 1010 XOR, 1011 XNOR; all others illegal unless REQ-024 applies.
REQ-014 Pipeline SHALL be two register stages: S1 captures op/a/b on accept; S2 captures computed c/flags when S1 advances.
REQ-015 Latency SHALL be exactly 2 cycles from accept edge to out_valid high, with out_ready held high; throughput one op per cycle.
REQ-016 S2 SHALL load when S2 is empty or retiring that cycle; S1 SHALL advance under the same condition.
REQ-017 in_ready SHALL equal !S1_valid || S1_advance (combinational; full throughput under continuous out_ready).
REQ-018 While out_valid && !out_ready, c and flags SHALL hold stable until retire.
REQ-019 ADD: c = (a+b) mod 2^WIDTH; carry = carry-out; ovf = signed overflow.
REQ-020 SUB: c = (a-b) mod 2^WIDTH; carry = 1 when a >= b unsigned (no borrow); ovf = signed overflow.
REQ-021 Logic ops: bitwise result; carry = ovf = 0.
REQ-022 zero = (c == 0); neg = c[WIDTH-1]; both for every legal op.
REQ-023 Illegal opcode: c = 0, err = 1, zero/neg/carry/ovf = 0; op still occupies one pipeline slot and retires normally.

Configuration
REQ-024 Macro ALU_PIPE_SHIFT_EN defined: opcodes 0100 SLL, 0101 SRL, 0110 SRA legal, shift amount b[log2(WIDTH)-1:0], upper b bits ignored, carry = last bit shifted out (0 for amount 0), ovf = 0; macro undefined: 0100/0101/0110 illegal per REQ-023 and no shifter logic synthesised.

Reset
REQ-025 rst_n low SHALL asynchronously clear S1_valid and S2_valid, c = 0, flags = 0; in_ready SHALL read 1 while S1 is empty.
REQ-026 In-flight operations at reset assertion SHALL be discarded, never retired.
REQ-027 First accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-028 Reset: assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0, c=0, flags=0 immediately, no retire of those ops after release.
REQ-029 Latency/throughput: WIDTH=32, out_ready=1, back-to-back ADD 1+2, SUB 5-7, XNOR 0/0 -> c=3, 0xFFFFFFFE (neg=1, carry=0), 0xFFFFFFFF on consecutive cycles starting 2 cycles after first accept.
REQ-030 Flags: ADD 0x7FFFFFFF+1 -> c=0x80000000, ovf=1, neg=1, carry=0; ADD 0xFFFFFFFF+1 -> c=0, zero=1, carry=1, ovf=0; SUB 4-4 -> zero=1, carry=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 ops accepted, in_ready=0 thereafter, c held; release -> ops retire in order, none lost or duplicated.
REQ-032 Illegal/config: op=1111 -> c=0, err=1; op=0100, a=0x1, b=4 -> without ALU_PIPE_SHIFT_EN err=1, with it c=0x10, err=0.
REQ-033 Width: WIDTH=8, ADD 0xFF+0x01 -> c=0x00, carry=1, zero=1; AND 0xF0&0x3C -> c=0x30.
